// File: rtl/reg_file_pkg.sv
// Shared integer-datapath definitions: register index types/constants and ALU op encodings.
// Types and constants only; no timing or flow control lives here.
package reg_file_pkg;

    localparam int XLEN       = 32;
    localparam int REG_AWIDTH = 5;
    localparam int REG_COUNT  = 2 ** REG_AWIDTH;

    typedef logic [REG_AWIDTH-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = '0;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLL  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9
    } alu_op_t;

endpackage

// File: rtl/reg_file_if.sv
// Register file access bundle: two operand read ports, one write port, one debug read port.
// Combinational reads, write accepted every cycle; no handshake and no backpressure.
interface reg_file_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5
);
    logic [AWIDTH-1:0] rs1_addr;
    logic [AWIDTH-1:0] rs2_addr;
    logic [DWIDTH-1:0] rs1_data;
    logic [DWIDTH-1:0] rs2_data;
    logic              we;
    logic [AWIDTH-1:0] rd_addr;
    logic [DWIDTH-1:0] rd_data;
    logic [AWIDTH-1:0] dbg_addr;
    logic [DWIDTH-1:0] dbg_data;

    modport master (
        output rs1_addr, rs2_addr, we, rd_addr, rd_data, dbg_addr,
        input  rs1_data, rs2_data, dbg_data
    );

    modport slave (
        input  rs1_addr, rs2_addr, we, rd_addr, rd_data, dbg_addr,
        output rs1_data, rs2_data, dbg_data
    );
endinterface

// File: rtl/reg_file_rport.sv
// One operand read port: x0 zero-check, optional same-cycle write forwarding, entry mux.
// Purely combinational (0 cycles); no backpressure.
module reg_file_rport
    import reg_file_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5,
    parameter int BYPASS = 1
) (
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] entry,
    input  logic              we,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    output logic [DWIDTH-1:0] data
);
    logic is_zero;
    logic fwd;

    assign is_zero = (addr == AWIDTH'(REG_ZERO));
    assign fwd     = (BYPASS != 0) && we && (wr_addr == addr);

    // Zero check wins over forwarding so an x0 write can never leak to a reader.
    always_comb begin
        data = entry;
        if (is_zero) begin
            data = '0;
        end else if (fwd) begin
            data = wr_data;
        end
    end
endmodule

// File: rtl/reg_file.sv
// Architectural register file, x0 hardwired to zero; reads 0-cycle combinational, writes commit on clk.
// Write port accepted unconditionally every cycle; no backpressure.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5,
    parameter int BYPASS = 1
) (
    input  logic       clk,
    input  logic       rstn,
    reg_file_if.slave  rf
);
    localparam int NREGS = 2 ** AWIDTH;

    logic [DWIDTH-1:0] mem [NREGS];

    // Entry 0 is cleared by reset and never written, so it holds zero and folds away.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (rf.we && (rf.rd_addr != AWIDTH'(REG_ZERO))) begin
            mem[rf.rd_addr] <= rf.rd_data;
        end
    end

    reg_file_rport #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .BYPASS(BYPASS)) u_rs1 (
        .addr    (rf.rs1_addr),
        .entry   (mem[rf.rs1_addr]),
        .we      (rf.we),
        .wr_addr (rf.rd_addr),
        .wr_data (rf.rd_data),
        .data    (rf.rs1_data)
    );

    reg_file_rport #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .BYPASS(BYPASS)) u_rs2 (
        .addr    (rf.rs2_addr),
        .entry   (mem[rf.rs2_addr]),
        .we      (rf.we),
        .wr_addr (rf.rd_addr),
        .wr_data (rf.rd_data),
        .data    (rf.rs2_data)
    );

    // Debug port shows committed state only, never the forwarded value.
    assign rf.dbg_data = (rf.dbg_addr == AWIDTH'(REG_ZERO)) ? '0 : mem[rf.dbg_addr];
endmodule

// File: tb/tb_reg_file.sv
// Directed and random bench for reg_file, driving a BYPASS=1 and a BYPASS=0 instance in lockstep.
module tb_reg_file;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    reg_file_if #(.DWIDTH(32), .AWIDTH(5)) if0 ();
    reg_file_if #(.DWIDTH(32), .AWIDTH(5)) if1 ();

    reg_file #(.DWIDTH(32), .AWIDTH(5), .BYPASS(1)) dut0 (.clk(clk), .rstn(rstn), .rf(if0.slave));
    reg_file #(.DWIDTH(32), .AWIDTH(5), .BYPASS(0)) dut1 (.clk(clk), .rstn(rstn), .rf(if1.slave));

    int checks = 0;
    int errors = 0;
    logic [31:0] model [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [4:0] rd, input logic [31:0] d,
                         input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
        if0.we = w;  if0.rd_addr = rd;  if0.rd_data = d;
        if0.rs1_addr = a1;  if0.rs2_addr = a2;  if0.dbg_addr = ad;
        if1.we = w;  if1.rd_addr = rd;  if1.rd_data = d;
        if1.rs1_addr = a1;  if1.rs2_addr = a2;  if1.dbg_addr = ad;
    endtask

    task automatic set_dbg(input logic [4:0] ad);
        if0.dbg_addr = ad;
        if1.dbg_addr = ad;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        drive(1'b1, a, d, 5'd0, 5'd0, 5'd0);
        @(posedge clk);
        #1;
        if0.we = 1'b0;
        if1.we = 1'b0;
        if (a != 5'd0) model[a] = d;
    endtask

    initial begin
        logic [31:0] sum, a_op, b_op, base1, base2, based;
        logic        ovf, w;
        logic [4:0]  rd, r1, r2, rdb;
        logic [31:0] d;

        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        rstn = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd17, 5'd9);
        #1;
        chk("reset_rs1", if0.rs1_data, 32'h0);
        chk("reset_rs2", if0.rs2_data, 32'h0);
        chk("reset_dbg", if1.dbg_data, 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        // Fill, then drop reset between edges and confirm immediate clear.
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'hFFFF_FFFF);
        set_dbg(5'd9);
        #1;
        chk("fill_dbg9_b1", if0.dbg_data, 32'hFFFF_FFFF);
        chk("fill_dbg9_b0", if1.dbg_data, 32'hFFFF_FFFF);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        #1;
        chk("async_clr_dbg9", if0.dbg_data, 32'h0);
        for (int i = 0; i < 32; i++) begin
            set_dbg(5'(i));
            #1;
            chk("async_clr_b1", if0.dbg_data, 32'h0);
            chk("async_clr_b0", if1.dbg_data, 32'h0);
        end
        @(negedge clk);
        rstn = 1'b1;
        write_reg(5'd5, 32'h0000_1234);
        set_dbg(5'd5);
        #1;
        chk("post_rst_x5_b1", if0.dbg_data, 32'h0000_1234);
        chk("post_rst_x5_b0", if1.dbg_data, 32'h0000_1234);

        // x0 hardwire: write attempt must not reach any port.
        @(negedge clk);
        drive(1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0, 5'd0);
        #1;
        chk("x0_pre_rs1_b1", if0.rs1_data, 32'h0);
        chk("x0_pre_rs2_b1", if0.rs2_data, 32'h0);
        chk("x0_pre_rs1_b0", if1.rs1_data, 32'h0);
        @(posedge clk);
        #1;
        chk("x0_post_rs1_b1", if0.rs1_data, 32'h0);
        chk("x0_post_rs2_b1", if0.rs2_data, 32'h0);
        chk("x0_post_dbg_b1", if0.dbg_data, 32'h0);
        chk("x0_post_rs2_b0", if1.rs2_data, 32'h0);
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);

        // Bypass versus committed value.
        write_reg(5'd7, 32'h0000_0010);
        @(negedge clk);
        drive(1'b1, 5'd7, 32'h0000_0020, 5'd7, 5'd7, 5'd7);
        #1;
        chk("byp_rs1_b1", if0.rs1_data, 32'h0000_0020);
        chk("byp_rs2_b1", if0.rs2_data, 32'h0000_0020);
        chk("byp_dbg_b1", if0.dbg_data, 32'h0000_0010);
        chk("nobyp_rs1_b0", if1.rs1_data, 32'h0000_0010);
        chk("nobyp_rs2_b0", if1.rs2_data, 32'h0000_0010);
        @(posedge clk);
        #1;
        if0.we = 1'b0;
        if1.we = 1'b0;
        model[7] = 32'h0000_0020;
        chk("byp_commit_b1", if0.dbg_data, 32'h0000_0020);
        chk("byp_commit_b0", if1.rs1_data, 32'h0000_0020);

        // Dual read independence, held across idle cycles.
        write_reg(5'd1, 32'h0000_0001);
        write_reg(5'd31, 32'h8000_0000);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            drive(1'b0, 5'($urandom_range(0, 31)), $urandom, 5'd1, 5'd31, 5'd31);
            #1;
            chk("dual_rs1_b1", if0.rs1_data, 32'h0000_0001);
            chk("dual_rs2_b1", if0.rs2_data, 32'h8000_0000);
            chk("dual_rs1_b0", if1.rs1_data, 32'h0000_0001);
            chk("dual_dbg_b0", if1.dbg_data, 32'h8000_0000);
        end

        // ALU loop: add rs1+rs2, write back to x3 in the same cycle.
        write_reg(5'd1, 32'h7FFF_FFFF);
        write_reg(5'd2, 32'h0000_0001);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 5'd3);
        #1;
        a_op = if0.rs1_data;
        b_op = if0.rs2_data;
        sum  = a_op + b_op;
        drive(1'b1, 5'd3, sum, 5'd1, 5'd2, 5'd3);
        #1;
        ovf = (a_op[31] == b_op[31]) && (sum[31] != a_op[31]);
        chk("alu_ovf", {31'h0, ovf}, 32'h1);
        chk("alu_sum", sum, 32'h8000_0000);
        @(posedge clk);
        #1;
        if0.we = 1'b0;
        if1.we = 1'b0;
        model[3] = 32'h8000_0000;
        chk("alu_x3_b1", if0.dbg_data, 32'h8000_0000);
        chk("alu_x3_b0", if1.dbg_data, 32'h8000_0000);

        // Random traffic against the reference array.
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            w   = 1'($urandom_range(0, 1));
            rd  = 5'($urandom_range(0, 31));
            d   = $urandom;
            r1  = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            r2  = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            rdb = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            drive(w, rd, d, r1, r2, rdb);
            #1;
            base1 = (r1 == 5'd0) ? 32'h0 : model[r1];
            base2 = (r2 == 5'd0) ? 32'h0 : model[r2];
            based = (rdb == 5'd0) ? 32'h0 : model[rdb];
            chk("rnd_rs1_b1", if0.rs1_data, (w && r1 != 5'd0 && rd == r1) ? d : base1);
            chk("rnd_rs2_b1", if0.rs2_data, (w && r2 != 5'd0 && rd == r2) ? d : base2);
            chk("rnd_dbg_b1", if0.dbg_data, based);
            chk("rnd_rs1_b0", if1.rs1_data, base1);
            chk("rnd_rs2_b0", if1.rs2_data, base2);
            chk("rnd_dbg_b0", if1.dbg_data, based);
            if (w && rd != 5'd0) model[rd] = d;
        end

        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
